// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// DATA_WIDTH falls back to 32 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package writeback_arbiter_pkg;

   localparam int unsigned WB_DATA_W  = `DATA_WIDTH;
   localparam int unsigned WB_THREADS = 16;
   localparam int unsigned REG_W      = 5;

   localparam logic [REG_W-1:0] ZERO_REG     = REG_W'(0);
   localparam logic [REG_W-1:0] RO_REG_FIRST = REG_W'(29);

   typedef logic [WB_DATA_W-1:0] data_t;

   typedef enum logic {
      ALU_OUT = 1'b0,
      LSU_OUT = 1'b1
   } reg_input_mux_t;

   typedef struct packed {
      data_t                                  warp_id;
      logic [REG_W-1:0]                       rd;
      logic [WB_THREADS-1:0]                  mask;
      logic [WB_THREADS-1:0][WB_DATA_W-1:0]   data;
      reg_input_mux_t                         mux;
   } wb_entry_t;

   // Zero register, read-only registers and empty masks never reach the register file.
   function automatic logic wb_is_drop(input wb_entry_t e);
      return (e.rd == ZERO_REG) || (e.rd >= RO_REG_FIRST) || (e.mask == '0);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result queue. A push and pop together on an empty queue pass the
// pushed entry straight to the head without storing it.
module wb_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = logic
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_push,
   input  T     i_push_data,
   input  logic i_pop,
   output T     o_head,
   output logic o_empty,
   output logic o_full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;
   logic w_thru;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign w_push  = i_push && (!o_full || i_pop);
   assign w_pop   = i_pop && (!o_empty || i_push);
   assign w_thru  = o_empty && w_push && w_pop;
   assign o_head  = o_empty ? i_push_data : r_mem[r_rptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push && !w_thru) r_wptr <= r_wptr + AW'(1);
         if (w_pop && !w_thru)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (w_push && !w_thru) r_mem[r_wptr] <= i_push_data;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter merging ALU and LSU results into one register-file port.
// Define WB_BYPASS_EN to let a result skip its empty queue straight into the output register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned THREADS_PER_WARP = WB_THREADS,
   parameter int unsigned DATA_WIDTH       = `DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH       = 2
) (
   input  logic                                        clk,
   input  logic                                        reset_n,

   input  logic                                        alu_valid,
   output logic                                        alu_ready,
   input  logic [DATA_WIDTH-1:0]                       alu_warp_id,
   input  logic [4:0]                                  alu_rd,
   input  logic [THREADS_PER_WARP-1:0]                 alu_mask,
   input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] alu_data,

   input  logic                                        lsu_valid,
   output logic                                        lsu_ready,
   input  logic [DATA_WIDTH-1:0]                       lsu_warp_id,
   input  logic [4:0]                                  lsu_rd,
   input  logic [THREADS_PER_WARP-1:0]                 lsu_mask,
   input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lsu_data,

   output logic                                        wb_valid,
   output logic [DATA_WIDTH-1:0]                       wb_warp_id,
   output logic [4:0]                                  wb_rd,
   output reg_input_mux_t                              wb_mux,
   output logic [THREADS_PER_WARP-1:0]                 wb_mask,
   output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] wb_data,
   input  logic                                        wb_ready,

   output logic [15:0]                                 drop_count
);

   wb_entry_t   r_wb;
   logic        r_wb_valid;
   logic        r_last_alu;
   logic        r_ready_en;
   logic [15:0] r_drop_count;

   wb_entry_t w_alu_entry;
   wb_entry_t w_lsu_entry;
   wb_entry_t w_alu_head;
   wb_entry_t w_lsu_head;
   wb_entry_t w_sel;
   logic      w_alu_empty, w_alu_full, w_lsu_empty, w_lsu_full;
   logic      w_alu_cand, w_lsu_cand;
   logic      w_gnt_alu, w_gnt_lsu;
   logic      w_can_load;
   logic      w_alu_pop, w_lsu_pop;
   logic      w_alu_push, w_lsu_push;
   logic      w_any;
   logic      w_drop;

   // Pack producer ports into queue entries tagged with their writeback source.
   always_comb begin
      w_alu_entry         = '0;
      w_alu_entry.warp_id = alu_warp_id;
      w_alu_entry.rd      = alu_rd;
      w_alu_entry.mask    = alu_mask;
      w_alu_entry.data    = alu_data;
      w_alu_entry.mux     = ALU_OUT;
      w_lsu_entry         = '0;
      w_lsu_entry.warp_id = lsu_warp_id;
      w_lsu_entry.rd      = lsu_rd;
      w_lsu_entry.mask    = lsu_mask;
      w_lsu_entry.data    = lsu_data;
      w_lsu_entry.mux     = LSU_OUT;
   end

   wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_entry_t)) u_alu_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_alu_push),
      .i_push_data (w_alu_entry),
      .i_pop       (w_alu_pop),
      .o_head      (w_alu_head),
      .o_empty     (w_alu_empty),
      .o_full      (w_alu_full)
   );

   wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_entry_t)) u_lsu_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_lsu_push),
      .i_push_data (w_lsu_entry),
      .i_pop       (w_lsu_pop),
      .o_head      (w_lsu_head),
      .o_empty     (w_lsu_empty),
      .o_full      (w_lsu_full)
   );

   // Round-robin grant: the source granted last loses a tie.
   always_comb begin
      w_alu_cand = !w_alu_empty;
      w_lsu_cand = !w_lsu_empty;
`ifdef WB_BYPASS_EN
      w_alu_cand = !w_alu_empty || (alu_valid && r_ready_en);
      w_lsu_cand = !w_lsu_empty || (lsu_valid && r_ready_en);
`endif
      w_can_load = !r_wb_valid || wb_ready;
      w_gnt_alu  = w_alu_cand && (!w_lsu_cand || !r_last_alu);
      w_gnt_lsu  = w_lsu_cand && !w_gnt_alu;
      w_alu_pop  = w_can_load && w_gnt_alu;
      w_lsu_pop  = w_can_load && w_gnt_lsu;
      w_any      = w_alu_pop || w_lsu_pop;
      w_sel      = w_alu_pop ? w_alu_head : w_lsu_head;
      w_drop     = wb_is_drop(w_sel);
   end

   assign alu_ready  = r_ready_en && (!w_alu_full || w_alu_pop);
   assign lsu_ready  = r_ready_en && (!w_lsu_full || w_lsu_pop);
   assign w_alu_push = alu_valid && alu_ready;
   assign w_lsu_push = lsu_valid && lsu_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wb         <= '0;
         r_wb_valid   <= 1'b0;
         r_last_alu   <= 1'b1;
         r_ready_en   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_any) r_last_alu <= w_alu_pop;
         if (w_can_load) begin
            r_wb_valid <= w_any && !w_drop;
            if (w_any && !w_drop) r_wb <= w_sel;
         end
         if (w_any && w_drop && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign wb_valid   = r_wb_valid;
   assign wb_warp_id = r_wb.warp_id;
   assign wb_rd      = r_wb.rd;
   assign wb_mux     = r_wb.mux;
   assign wb_mask    = r_wb.mask;
   assign wb_data    = r_wb.data;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter; latency expectations follow WB_BYPASS_EN.
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int unsigned T = WB_THREADS;
   localparam int unsigned D = WB_DATA_W;
`ifdef WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic                clk = 1'b0;
   logic                reset_n;
   logic                alu_valid, lsu_valid, wb_ready;
   logic                alu_ready, lsu_ready, wb_valid;
   logic [D-1:0]        alu_warp_id, lsu_warp_id, wb_warp_id;
   logic [4:0]          alu_rd, lsu_rd, wb_rd;
   logic [T-1:0]        alu_mask, lsu_mask, wb_mask;
   logic [T-1:0][D-1:0] alu_data, lsu_data, wb_data;
   reg_input_mux_t      wb_mux;
   logic [15:0]         drop_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int mon_rd[$];
   int mon_mux[$];
   int mon_cyc[$];

   writeback_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_warp_id(alu_warp_id),
      .alu_rd(alu_rd), .alu_mask(alu_mask), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_warp_id(lsu_warp_id),
      .lsu_rd(lsu_rd), .lsu_mask(lsu_mask), .lsu_data(lsu_data),
      .wb_valid(wb_valid), .wb_warp_id(wb_warp_id), .wb_rd(wb_rd), .wb_mux(wb_mux),
      .wb_mask(wb_mask), .wb_data(wb_data), .wb_ready(wb_ready),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted write.
   always @(negedge clk) begin
      if (reset_n && wb_valid && wb_ready) begin
         mon_rd.push_back(int'(wb_rd));
         mon_mux.push_back(int'(wb_mux));
         mon_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int base;
      int acc;
      int next_rd;
      int exp_rd[4];
      int exp_mux[4];

      reset_n = 1'b0;
      alu_valid = 1'b0; lsu_valid = 1'b0; wb_ready = 1'b1;
      alu_warp_id = '0; lsu_warp_id = '0; alu_rd = '0; lsu_rd = '0;
      alu_mask = '0; lsu_mask = '0; alu_data = '0; lsu_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_rd", 64'(wb_rd), 64'd0);
      check("rst_wb_mux", 64'(wb_mux), 64'(ALU_OUT));
      check("rst_drop_count", 64'(drop_count), 64'd0);
      check("rst_alu_ready", 64'(alu_ready), 64'd0);
      check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      @(posedge clk);
      #3 reset_n = 1'b1;
      #1 check("ready_before_edge", 64'(alu_ready), 64'd0);
      step();
      check("ready_alu_after_edge", 64'(alu_ready), 64'd1);
      check("ready_lsu_after_edge", 64'(lsu_ready), 64'd1);

      // Single ALU push and its latency
      alu_valid = 1'b1; alu_warp_id = D'(3); alu_rd = 5'd5; alu_mask = 16'hFFFF;
      for (int i = 0; i < int'(T); i++) alu_data[i] = D'(i * 2);
      for (int k = 1; k <= LAT; k++) begin
         step();
         alu_valid = 1'b0;
         check($sformatf("lat_valid_%0d", k), 64'(wb_valid), 64'(k == LAT));
      end
      check("t1_rd", 64'(wb_rd), 64'd5);
      check("t1_warp", 64'(wb_warp_id), 64'd3);
      check("t1_mux", 64'(wb_mux), 64'(ALU_OUT));
      check("t1_mask", 64'(wb_mask), 64'hFFFF);
      check("t1_data1", 64'(wb_data[1]), 64'd2);
      check("t1_data15", 64'(wb_data[15]), 64'd30);
      step();
      check("t1_done", 64'(wb_valid), 64'd0);

      // Ties: LSU first, then a back-to-back tie goes to ALU
      base = mon_rd.size();
      alu_valid = 1'b1; alu_rd = 5'd6; alu_warp_id = D'(1); alu_mask = 16'hFFFF;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_warp_id = D'(2); lsu_mask = 16'hFFFF;
      step();
      alu_rd = 5'd8; lsu_rd = 5'd9;
      step();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (6) step();
      exp_rd  = '{7, 6, 9, 8};
      exp_mux = '{int'(LSU_OUT), int'(ALU_OUT), int'(LSU_OUT), int'(ALU_OUT)};
      check("tie_count", 64'(mon_rd.size() - base), 64'd4);
      if (mon_rd.size() - base == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_rd_%0d", i), 64'(mon_rd[base+i]), 64'(exp_rd[i]));
            check($sformatf("tie_mux_%0d", i), 64'(mon_mux[base+i]), 64'(exp_mux[i]));
         end
         for (int i = 1; i < 4; i++)
            check($sformatf("tie_gap_%0d", i), 64'(mon_cyc[base+i] - mon_cyc[base+i-1]), 64'd1);
      end

      // Stall with continuous ALU pushes
      wb_ready = 1'b0;
      acc = 0;
      next_rd = 10;
      alu_mask = 16'hFFFF; alu_warp_id = D'(4);
      for (int i = 0; i < 6; i++) begin
         alu_valid = 1'b1;
         alu_rd = 5'(next_rd);
         #1;
         if (alu_ready) begin
            acc++;
            next_rd++;
         end
         step();
         if (wb_valid) check($sformatf("stall_rd_%0d", i), 64'(wb_rd), 64'd10);
      end
      alu_rd = 5'(next_rd);
      #1 check("stall_ready_low", 64'(alu_ready), 64'd0);
      check("stall_accepts", 64'(acc), 64'(2 + 1));
      check("stall_valid", 64'(wb_valid), 64'd1);
      base = mon_rd.size();
      alu_valid = 1'b0;
      wb_ready = 1'b1;
      repeat (6) step();
      check("drain_count", 64'(mon_rd.size() - base), 64'd3);
      if (mon_rd.size() - base == 3)
         for (int i = 0; i < 3; i++)
            check($sformatf("drain_rd_%0d", i), 64'(mon_rd[base+i]), 64'(10 + i));

      // Dropped entries
      check("drop_before", 64'(drop_count), 64'd0);
      base = mon_rd.size();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_mask = 16'hFFFF;
      step();
      alu_rd = 5'd30;
      step();
      alu_rd = 5'd5; alu_mask = 16'h0000;
      step();
      alu_valid = 1'b0;
      repeat (5) step();
      check("drop_no_write", 64'(mon_rd.size() - base), 64'd0);
      check("drop_count", 64'(drop_count), 64'd3);

      // Asynchronous reset with both queues full
      wb_ready = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd20; alu_mask = 16'hFFFF;
      lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_mask = 16'hFFFF;
      repeat (5) step();
      check("full_alu_ready", 64'(alu_ready), 64'd0);
      check("full_lsu_ready", 64'(lsu_ready), 64'd0);
      check("full_wb_valid", 64'(wb_valid), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_wb_valid", 64'(wb_valid), 64'd0);
      check("arst_wb_rd", 64'(wb_rd), 64'd0);
      check("arst_wb_warp", 64'(wb_warp_id), 64'd0);
      check("arst_wb_mask", 64'(wb_mask), 64'd0);
      check("arst_wb_data0", 64'(wb_data[0]), 64'd0);
      check("arst_drop", 64'(drop_count), 64'd0);
      check("arst_alu_ready", 64'(alu_ready), 64'd0);
      check("arst_lsu_ready", 64'(lsu_ready), 64'd0);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b1;
      wb_ready = 1'b1;
      base = mon_rd.size();
      step();
      check("rel_alu_ready", 64'(alu_ready), 64'd1);
      check("rel_lsu_ready", 64'(lsu_ready), 64'd1);
      repeat (5) step();
      check("rel_no_stale", 64'(mon_rd.size() - base), 64'd0);
      check("rel_wb_valid", 64'(wb_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
